ysyx_22040088_lsu: RTL and testbench

- Load/store unit; consumes the memory-access controls produced by instruction decode: mem_ena, mem_wen, one-hot mem_mask, and the unsigned-load flag.
- Executes exactly one access at a time over a 64-bit, 8-byte-aligned data-bus request/response interface.
- Loads: returns the extended 64-bit result. Stores: returns a completion.
- Sits between execute/writeback and the data memory / DPI memory model.

---
 rtl/ysyx_22040088_lsu.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_22040088_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: one access at a time over a 64-bit aligned request/response bus.
// Optional watchdog on REQ/WAIT enabled by defining YSYX_22040088_LSU_TIMEOUT_EN.

module ysyx_22040088_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0]  off,
  input  logic [3:0]  nbytes,
  input  logic        wen,
  input  logic [63:0] wdata,
  output logic        strb,
  output logic [7:0]  wbyte
);
  localparam logic [2:0] L = 3'(LANE);
  logic [2:0] rel;
  logic       hit;

  // Lane L carries source byte L-off once the store data is shifted up by off bytes.
  assign rel   = L - off;
  assign hit   = (L >= off);
  assign strb  = wen & hit & ({1'b0, rel} < nbytes);
  assign wbyte = hit ? wdata[{rel, 3'b000} +: 8] : 8'h00;
endmodule

module ysyx_22040088_lsu #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_wen,
  input  logic [3:0]        lsu_mask,
  input  logic              lsu_unsigned,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [63:0]       lsu_wdata,
  output logic              lsu_resp_valid,
  output logic [63:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [7:0]        bus_wstrb,
  output logic [63:0]       bus_wdata,
  input  logic              bus_resp_valid,
  input  logic [63:0]       bus_rdata,
  input  logic              bus_resp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q, uns_q, err_q;
  logic [3:0]        mask_q, size_q, in_size;
  logic [63:0]       wdata_q, rdata_q, sh, ld;
  logic [7:0][7:0]   wlanes;
  logic              accept, in_bad, misal, rsp_take, tmo;

  function automatic logic [3:0] size_of(input logic [3:0] m);
    case (m)
      4'b0001: size_of = 4'd8;
      4'b0010: size_of = 4'd4;
      4'b0100: size_of = 4'd2;
      4'b1000: size_of = 4'd1;
      default: size_of = 4'd0;
    endcase
  endfunction

  assign accept  = lsu_valid & (state_q == IDLE);
  assign in_size = size_of(lsu_mask);
  assign size_q  = size_of(mask_q);

  always_comb begin
    misal = 1'b0;
    case (in_size)
      4'd8:    misal = |lsu_addr[2:0];
      4'd4:    misal = |lsu_addr[1:0];
      4'd2:    misal = lsu_addr[0];
      default: misal = 1'b0;
    endcase
  end
  assign in_bad = (in_size == 4'd0) | misal;

  // Load extraction feeds only the rdata register, never an output directly.
  assign sh = bus_rdata >> {addr_q[2:0], 3'b000};
  always_comb begin
    ld = bus_rdata;
    case (size_q)
      4'd1: ld = uns_q ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      4'd2: ld = uns_q ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      4'd4: ld = uns_q ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ld = bus_rdata;
    endcase
  end

`ifdef YSYX_22040088_LSU_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign tmo = ((state_q == REQ) | ((state_q == WAIT) & ~bus_resp_valid))
             & ((cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES));
  always_ff @(posedge clk) begin
    if (!rst_n)                                  cnt_q <= 8'd0;
    else if (accept)                             cnt_q <= 8'd0;
    else if ((state_q == REQ) | (state_q == WAIT)) cnt_q <= cnt_q + 8'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^8'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif

  assign rsp_take = (state_q == WAIT) & bus_resp_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = in_bad ? RESP : REQ;
      REQ:  if (bus_req_ready) state_d = WAIT;
      WAIT: if (bus_resp_valid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = RESP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        uns_q   <= lsu_unsigned;
        mask_q  <= lsu_mask;
        wdata_q <= lsu_wdata;
        if (in_bad) begin
          rdata_q <= 64'd0;
          err_q   <= 1'b1;
        end
      end
      if (rsp_take) begin
        err_q   <= bus_resp_err;
        rdata_q <= (bus_resp_err | wen_q) ? 64'd0 : ld;
      end
      if (tmo) begin
        err_q   <= 1'b1;
        rdata_q <= 64'd0;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    ysyx_22040088_lsu_lane #(.LANE(g)) u_lane (
      .off    (addr_q[2:0]),
      .nbytes (size_q),
      .wen    (wen_q),
      .wdata  (wdata_q),
      .strb   (bus_wstrb[g]),
      .wbyte  (wlanes[g])
    );
  end

  assign lsu_ready      = (state_q == IDLE);
  assign lsu_resp_valid = (state_q == RESP);
  assign lsu_rdata      = rdata_q;
  assign lsu_err        = err_q;
  assign bus_req_valid  = (state_q == REQ);
  assign bus_addr       = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus_wen        = wen_q;
  assign bus_wdata      = wlanes;
endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Directed bench for ysyx_22040088_lsu: loads, stores, illegal accesses, stall/error, reset.
module tb_ysyx_22040088_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_ready, lsu_wen, lsu_unsigned;
  logic [3:0]  lsu_mask;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_resp_valid, lsu_err;
  logic        bus_req_valid, bus_req_ready, bus_wen, bus_resp_valid, bus_resp_err;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22040088_lsu #(.ADDR_W(64), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_mask(lsu_mask), .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns in cycle 1 after accept.
  task automatic issue(input logic wen, input logic [3:0] mask, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    lsu_valid = 1'b1; lsu_wen = wen; lsu_mask = mask; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    step();
    lsu_valid = 1'b0; lsu_addr = 64'hDEAD_DEAD_DEAD_DEAD; lsu_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    lsu_mask = 4'b0011; lsu_wen = ~wen; lsu_unsigned = ~uns;
  endtask

  initial begin
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_mask = 4'd0; lsu_unsigned = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    bus_rdata = '0; bus_resp_err = 1'b0;
    step(); step();
    chk("rst_ready", lsu_ready, 1);
    chk("rst_resp_valid", lsu_resp_valid, 0);
    chk("rst_req_valid", bus_req_valid, 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_wen", bus_wen, 0);
    rst_n = 1'b1;
    step();

    // Signed byte load, best-case latency; resp_valid held high through REQ.
    bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_rdata = 64'h0000_0000_F000_0000;
    issue(1'b0, 4'b1000, 1'b0, 64'h8000_0003, 64'h0);
    chk("lb_c1_req_valid", bus_req_valid, 1);
    chk("lb_c1_ready", lsu_ready, 0);
    chk("lb_c1_addr", bus_addr, 64'h8000_0000);
    chk("lb_c1_wstrb", bus_wstrb, 8'h00);
    chk("lb_c1_wen", bus_wen, 0);
    chk("lb_c1_resp", lsu_resp_valid, 0);
    step();
    chk("lb_c2_req_valid", bus_req_valid, 0);
    chk("lb_c2_resp", lsu_resp_valid, 0);
    step();
    chk("lb_c3_resp", lsu_resp_valid, 1);
    chk("lb_c3_rdata", lsu_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("lb_c3_err", lsu_err, 0);
    step();
    chk("lb_c4_resp", lsu_resp_valid, 0);
    chk("lb_c4_ready", lsu_ready, 1);
    chk("lb_c4_hold", lsu_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    step();
    chk("idle_resp_ignored", lsu_resp_valid, 0);

    // Unsigned half load at offset 6.
    bus_rdata = 64'h8001_0000_0000_0000;
    issue(1'b0, 4'b0100, 1'b1, 64'h8000_0006, 64'h0);
    step(); step();
    chk("lhu_resp", lsu_resp_valid, 1);
    chk("lhu_rdata", lsu_rdata, 64'h0000_0000_0000_8001);
    step();

    // Signed word load at offset 0.
    bus_rdata = 64'h0123_4567_89AB_CDEF;
    issue(1'b0, 4'b0010, 1'b0, 64'h8000_0010, 64'h0);
    step(); step();
    chk("lw_rdata", lsu_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    step();

    // Doubleword load ignores the unsigned flag.
    bus_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    issue(1'b0, 4'b0001, 1'b1, 64'h8000_0008, 64'h0);
    step(); step();
    chk("ld_rdata", lsu_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    step();

    // Word store in the upper half.
    bus_resp_valid = 1'b0;
    issue(1'b1, 4'b0010, 1'b0, 64'h8000_0004, 64'h1122_3344_5566_7788);
    chk("sw_wen", bus_wen, 1);
    chk("sw_wstrb", bus_wstrb, 8'hF0);
    chk("sw_wdata", bus_wdata, 64'h5566_7788_0000_0000);
    chk("sw_addr", bus_addr, 64'h8000_0000);
    bus_resp_valid = 1'b1;
    step(); step();
    chk("sw_resp", lsu_resp_valid, 1);
    chk("sw_rdata", lsu_rdata, 0);
    chk("sw_err", lsu_err, 0);
    step();

    // Byte store at offset 5.
    issue(1'b1, 4'b1000, 1'b0, 64'h8000_0015, 64'h0000_0000_0000_00AB);
    chk("sb_wstrb", bus_wstrb, 8'h20);
    chk("sb_wdata", bus_wdata, 64'h0000_AB00_0000_0000);
    step(); step(); step();

    // Misaligned doubleword and illegal masks: error at cycle 1, no bus request.
    issue(1'b0, 4'b0001, 1'b0, 64'h8000_0004, 64'h0);
    chk("mis_resp", lsu_resp_valid, 1);
    chk("mis_err", lsu_err, 1);
    chk("mis_req_valid", bus_req_valid, 0);
    chk("mis_rdata", lsu_rdata, 0);
    step();
    chk("mis_ready", lsu_ready, 1);
    issue(1'b0, 4'b0011, 1'b0, 64'h8000_0000, 64'h0);
    chk("ill_resp", lsu_resp_valid, 1);
    chk("ill_err", lsu_err, 1);
    chk("ill_req_valid", bus_req_valid, 0);
    step();
    issue(1'b1, 4'b0000, 1'b0, 64'h8000_0000, 64'h0);
    chk("ill0_err", lsu_err, 1);
    chk("ill0_req_valid", bus_req_valid, 0);
    step();
    issue(1'b0, 4'b0100, 1'b0, 64'h8000_0003, 64'h0);
    chk("mis_half_err", lsu_err, 1);
    step();

    // Stall five cycles in REQ, then a bus error.
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    issue(1'b0, 4'b1000, 1'b0, 64'h8000_0015, 64'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", bus_req_valid, 1);
      chk("stall_addr", bus_addr, 64'h8000_0010);
      chk("stall_wen", bus_wen, 0);
      chk("stall_wstrb", bus_wstrb, 8'h00);
      step();
    end
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    chk("stall_wait_req", bus_req_valid, 0);
    step();
    chk("stall_wait_resp", lsu_resp_valid, 0);
    bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("berr_resp", lsu_resp_valid, 1);
    chk("berr_err", lsu_err, 1);
    chk("berr_rdata", lsu_rdata, 0);
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    step();

    // Reset while in WAIT, then a stale response.
    bus_req_ready = 1'b1;
    issue(1'b0, 4'b0001, 1'b0, 64'h8000_0000, 64'h0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus_resp_valid = 1'b1;
    chk("rstw_ready", lsu_ready, 1);
    chk("rstw_err_cleared", lsu_err, 0);
    step();
    chk("rstw_resp", lsu_resp_valid, 0);
    chk("rstw_ready2", lsu_ready, 1);
    bus_resp_valid = 1'b0;
    step();

`ifdef YSYX_22040088_LSU_TIMEOUT_EN
    begin
      int n;
      bus_req_ready = 1'b1;
      issue(1'b0, 4'b0001, 1'b0, 64'h8000_0000, 64'h0);
      n = 0;
      while (!lsu_resp_valid && n < 50) begin
        step();
        n++;
      end
      chk("tmo_cycles", 64'(n), 64'd10);
      chk("tmo_err", lsu_err, 1);
      chk("tmo_rdata", lsu_rdata, 0);
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
